aes_sbox_word_sched: RTL and testbench

- Sequencer that drives one shared, pipelined aes_sbox with a 32-bit masked word (4 bytes x SHARES).
- Accepts words over a valid/ready handshake and issues one byte per cycle, but only when fresh randomness is available.
- Tracks in-flight bytes through the fixed sbox latency and reassembles the four substituted bytes into an output word, adding the affine constant once.
- Sits between the round datapath (SubBytes column) and the aes_sbox instance; the sbox itself and the PRNG are outside this block.

---
 rtl/aes_sbox_word_sched_pkg.sv | 28 ++
 rtl/aes_sbox_word_collect.sv | 46 ++++
 rtl/aes_sbox_word_sched.sv | 96 +++++++++
 tb/tb_aes_sbox_word_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sbox_word_sched_pkg.sv
// Shared types and helpers for the masked S-box word sequencer.
// Share slicing, affine constant and FSM encoding live here.
package aes_sbox_word_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] AFFINE_CONST = 8'h63;

    function automatic logic [7:0] share_byte(
        input logic [31:0] w,
        input logic [1:0]  b
    );
        return w[8*b +: 8];
    endfunction

    function automatic logic [7:0] affine_add(
        input logic [7:0] x,
        input logic       en
    );
        return en ? (x ^ AFFINE_CONST) : x;
    endfunction

endpackage

// File: rtl/aes_sbox_word_collect.sv
// Tracks in-flight bytes through the S-box pipeline and reassembles
// the substituted bytes into the output word.
module aes_sbox_word_collect #(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 5,
    parameter int ADD_AFFINE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [8*SHARES-1:0]   sbox_out,
    output logic                  last,
    output logic [32*SHARES-1:0]  word
);
    import aes_sbox_word_sched_pkg::*;

    logic [SBOX_LATENCY-1:0] vsr;
    logic [1:0]              cap_cnt;
    logic                    tail;

    assign tail = vsr[SBOX_LATENCY-1];
    assign last = tail && (cap_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr     <= '0;
            cap_cnt <= 2'd0;
            word    <= '0;
        end else begin
            vsr[0] <= push;
            for (int i = 1; i < SBOX_LATENCY; i++) begin
                vsr[i] <= vsr[i-1];
            end
            // Results return in issue order, so a counter is enough.
            if (tail) begin
                cap_cnt <= cap_cnt + 2'd1;
                for (int s = 0; s < SHARES; s++) begin
                    word[s*32 + 8*cap_cnt +: 8] <= affine_add(
                        sbox_out[s*8 +: 8],
                        (ADD_AFFINE != 0) && (s == 0));
                end
            end
        end
    end

endmodule

// File: rtl/aes_sbox_word_sched.sv
// Feeds one pipelined masked S-box a byte per cycle from a 32-bit
// word, gated by PRNG availability, and returns the substituted word.
module aes_sbox_word_sched #(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 5,
    parameter int ADD_AFFINE   = 1
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic [32*SHARES-1:0]  _DataxDI,
    input  logic                  InValidxSI,
    output logic                  InReadyxSO,
    output logic [8*SHARES-1:0]   _SboxInxDO,
    input  logic [8*SHARES-1:0]   _SboxOutxDI,
    input  logic                  RandValidxSI,
    output logic                  RandReqxSO,
    output logic [32*SHARES-1:0]  _DataxDO,
    output logic                  OutValidxSO,
    input  logic                  OutReadyxSI,
    output logic                  BusyxSO
);
    import aes_sbox_word_sched_pkg::*;

    state_t                state;
    logic [1:0]            issue_cnt;
    logic [32*SHARES-1:0]  in_word;
    logic                  issue;
    logic                  last;

    assign issue       = (state == ISSUE) && RandValidxSI;
    assign RandReqxSO  = issue;
    assign InReadyxSO  = (state == IDLE);
    assign OutValidxSO = (state == DONE);
    assign BusyxSO     = (state != IDLE);

    // Idle cycles drive zero so no stale share reaches the S-box.
    always_comb begin
        _SboxInxDO = '0;
        if (issue) begin
            for (int s = 0; s < SHARES; s++) begin
                _SboxInxDO[s*8 +: 8] =
                    share_byte(in_word[s*32 +: 32], issue_cnt);
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state     <= IDLE;
            issue_cnt <= 2'd0;
            in_word   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (InValidxSI) begin
                        in_word   <= _DataxDI;
                        issue_cnt <= 2'd0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (RandValidxSI) begin
                        issue_cnt <= issue_cnt + 2'd1;
                        if (issue_cnt == 2'd3) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (OutReadyxSI) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    aes_sbox_word_collect #(
        .SHARES       (SHARES),
        .SBOX_LATENCY (SBOX_LATENCY),
        .ADD_AFFINE   (ADD_AFFINE)
    ) u_collect (
        .clk      (ClkxCI),
        .rst_n    (RstxBI),
        .push     (issue),
        .sbox_out (_SboxOutxDI),
        .last     (last),
        .word     (_DataxDO)
    );

endmodule

// File: tb/tb_aes_sbox_word_sched.sv
// Directed bench for aes_sbox_word_sched with a behavioural masked
// S-box (remasking, fixed latency) attached to two DUT variants.
module tb_aes_sbox_word_sched;

    localparam int SH = 2;
    localparam int L  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] data;
    logic        in_valid, rand_valid, out_ready;

    logic        in_ready1, rand_req1, out_valid1, busy1;
    logic [15:0] sin1, sout1;
    logic [63:0] dout1;
    logic        in_ready0, rand_req0, out_valid0, busy0;
    logic [15:0] sin0, sout0;
    logic [63:0] dout0;

    int cyc = 0;
    int req_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    int c0, base, lat;
    logic [31:0] d, m, expw;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rand_req1) req_cnt <= req_cnt + 1;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(logic [7:0] x);
        logic [7:0] r = 8'h00;
        for (int i = 1; i < 256; i++) begin
            if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) r = 8'(i);
        end
        return r;
    endfunction

    // S-box without the additive constant
    function automatic logic [7:0] sbox_nc(logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    function automatic logic [15:0] remask(logic [15:0] x);
        logic [7:0] y, r;
        y = sbox_nc(x[7:0] ^ x[15:8]);
        r = 8'($urandom);
        return {r, y ^ r};
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_nc(w[8*b +: 8]) ^ 8'h63;
        return r;
    endfunction

    function automatic logic [31:0] unmask(logic [63:0] w);
        return w[31:0] ^ w[63:32];
    endfunction

    logic [15:0] p1 [L];
    logic [15:0] p0 [L];
    always @(posedge clk) begin
        p1[0] <= remask(sin1);
        p0[0] <= remask(sin0);
        for (int i = 1; i < L; i++) begin
            p1[i] <= p1[i-1];
            p0[i] <= p0[i-1];
        end
    end
    assign sout1 = p1[L-1];
    assign sout0 = p0[L-1];

    aes_sbox_word_sched #(.SHARES(SH), .SBOX_LATENCY(L), .ADD_AFFINE(1)) dut (
        .ClkxCI(clk), .RstxBI(rst_n), ._DataxDI(data), .InValidxSI(in_valid),
        .InReadyxSO(in_ready1), ._SboxInxDO(sin1), ._SboxOutxDI(sout1),
        .RandValidxSI(rand_valid), .RandReqxSO(rand_req1), ._DataxDO(dout1),
        .OutValidxSO(out_valid1), .OutReadyxSI(out_ready), .BusyxSO(busy1)
    );

    aes_sbox_word_sched #(.SHARES(SH), .SBOX_LATENCY(L), .ADD_AFFINE(0)) dut0 (
        .ClkxCI(clk), .RstxBI(rst_n), ._DataxDI(data), .InValidxSI(in_valid),
        .InReadyxSO(in_ready0), ._SboxInxDO(sin0), ._SboxOutxDI(sout0),
        .RandValidxSI(rand_valid), .RandReqxSO(rand_req0), ._DataxDO(dout0),
        .OutValidxSO(out_valid0), .OutReadyxSI(out_ready), .BusyxSO(busy0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            #1;
            if (out_valid1) begin
                lat = cyc - c0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        in_valid = 0; data = '0; rand_valid = 0; out_ready = 0;
        step(); step(); #1;
        check("rst_in_ready", in_ready1, 1);
        check("rst_out_valid", out_valid1, 0);
        check("rst_rand_req", rand_req1, 0);
        check("rst_sbox_in", sin1, 0);
        check("rst_busy", busy1, 0);
        check("rst_data", dout1, 0);

        // nominal word, both affine settings
        step(); rst_n = 1; rand_valid = 1; out_ready = 1;
        step(); data = 64'hA5A5A5A5_5AF6A4A5; in_valid = 1; c0 = cyc; base = req_cnt;
        step(); in_valid = 0;
        wait_valid(40);
        check("nom_latency", lat, 10);
        check("nom_data", unmask(dout1), 32'h16ED7C63);
        check("noaff_valid", out_valid0, 1);
        check("noaff_data", unmask(dout0), 32'h758E1F00);
        check("nom_req", req_cnt - base, 4);
        step(); #1;
        check("nom_idle_ready", in_ready1, 1);
        check("nom_idle_valid", out_valid1, 0);

        // randomness stall of 3 cycles between byte1 and byte2
        data = 64'hA5A5A5A5_5AF6A4A5; in_valid = 1; c0 = cyc; base = req_cnt;
        step(); in_valid = 0; #1;
        check("stall_b0_in", sin1, 16'hA5A5);
        check("stall_b0_req", rand_req1, 1);
        step(); #1;
        check("stall_b1_in", sin1, 16'hA5A4);
        for (int k = 0; k < 3; k++) begin
            step(); rand_valid = 0; #1;
            check("stall_bubble_in", sin1, 0);
            check("stall_bubble_req", rand_req1, 0);
        end
        step(); rand_valid = 1;
        wait_valid(40);
        check("stall_latency", lat, 13);
        check("stall_data", unmask(dout1), 32'h16ED7C63);
        check("stall_req", req_cnt - base, 4);
        step();

        // output backpressure with a competing input word
        out_ready = 0;
        data = 64'h3C3C3C3C_7C0C1C2C; in_valid = 1; c0 = cyc; base = req_cnt;
        step(); in_valid = 0;
        wait_valid(40);
        check("bp_latency", lat, 10);
        check("bp_data", unmask(dout1), 32'h0904B7CA);
        for (int k = 0; k < 10; k++) begin
            step(); in_valid = 1; data = 64'h12345678_4167052B; #1;
            check("bp_hold_valid", out_valid1, 1);
            check("bp_hold_ready", in_ready1, 0);
            check("bp_hold_data", unmask(dout1), 32'h0904B7CA);
            check("bp_hold_req", rand_req1, 0);
        end
        step(); out_ready = 1;
        step(); #1;
        check("bp_rel_ready", in_ready1, 1);
        check("bp_rel_valid", out_valid1, 0);
        c0 = cyc; base = req_cnt;
        step(); in_valid = 0;
        wait_valid(40);
        check("bp2_latency", lat, 10);
        check("bp2_data", unmask(dout1), 32'hEDEDEDED);
        check("bp2_req", req_cnt - base, 4);
        step();

        // reset during DRAIN, then an all-zero word
        data = 64'hA5A5A5A5_5AF6A4A5; in_valid = 1; c0 = cyc;
        step(); in_valid = 0;
        repeat (5) step();
        #1;
        check("drain_busy", busy1, 1);
        check("drain_ready", in_ready1, 0);
        rst_n = 0; #1;
        check("arst_valid", out_valid1, 0);
        check("arst_ready", in_ready1, 1);
        check("arst_data", dout1, 0);
        step(); rst_n = 1;
        data = '0; in_valid = 1; c0 = cyc; base = req_cnt;
        step(); in_valid = 0;
        wait_valid(40);
        check("post_rst_latency", lat, 10);
        check("post_rst_data", unmask(dout1), 32'h63636363);
        check("post_rst_noaff", unmask(dout0), 32'h00000000);
        check("post_rst_req", req_cnt - base, 4);
        step();

        // back-to-back random words with random PRNG availability
        base = req_cnt;
        for (int w = 0; w < 8; w++) begin
            d = $urandom; m = $urandom; expw = ref_word(d);
            data = {m, d ^ m}; in_valid = 1; #1;
            check("rnd_ready", in_ready1, 1);
            step(); in_valid = 0;
            lat = -1;
            for (int i = 0; i < 80; i++) begin
                rand_valid = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid1) begin
                    lat = i;
                    break;
                end
                @(negedge clk);
            end
            check("rnd_done", lat >= 0, 1);
            check("rnd_data", unmask(dout1), expw);
            check("rnd_noaff", unmask(dout0), expw ^ 32'h63636363);
            step();
        end
        check("rnd_req", req_cnt - base, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
